// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port-per-direction BRAM. Requesters A and B
// share the RAM; a clear sweep can zero the whole memory. Read returns are tracked by a
// two-stage owner tag so each requester sees its own rvalid two cycles after acceptance.
module bram_arbiter #(
  parameter int unsigned PRIO_MODE = 1  // 1: round-robin, 0: fixed priority (A wins)
) (
  input  logic        clk,
  input  logic        rst_n,
  // Requester A
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [15:0] a_wdata,
  input  logic [15:0] a_mask,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  // Requester B
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_wdata,
  input  logic [15:0] b_mask,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  // Clear control
  input  logic        clr_start,
  output logic        clr_busy,
  // RAM side
  output logic [7:0]  bram_waddr,
  output logic [7:0]  bram_raddr,
  output logic [15:0] bram_wdata,
  output logic [15:0] bram_mask,
  output logic        bram_we,
  output logic        bram_wclke,
  output logic        bram_re,
  output logic        bram_rclke,
  input  logic [15:0] bram_rdata
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        rr_q;  // 0: A has priority on contention, 1: B
  logic        tag1_v_q, tag1_b_q, tag2_v_q, tag2_b_q;
  logic [7:0]  waddr_q, raddr_q;
  logic [15:0] wdata_q, mask_q;
  logic        we_q, re_q;

  logic        can_grant, accept, sel_b, sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata, sel_mask;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter CLEAR on clr_start, leave after the write for address 255
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clr_start) state_d = StClear;
      StClear: if (cnt_q == 8'hFF) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs of the FSM: busy flag and grants (only in IDLE, never while clearing starts)
  always_comb begin
    clr_busy  = (state_q == StClear);
    can_grant = rst_n && (state_q == StIdle) && !clr_start;
    a_gnt     = can_grant && a_req && (!b_req || (PRIO_MODE == 0) || !rr_q);
    b_gnt     = can_grant && b_req && (!a_req || ((PRIO_MODE != 0) && rr_q));
  end

  // Select the accepted request's fields
  always_comb begin
    accept    = a_gnt || b_gnt;
    sel_b     = b_gnt;
    sel_we    = sel_b ? b_we    : a_we;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    sel_mask  = sel_b ? b_mask  : a_mask;
  end

  // Registered RAM interface, clear counter, round-robin pointer and read-owner tags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 8'h00;
      rr_q     <= 1'b0;
      tag1_v_q <= 1'b0;
      tag1_b_q <= 1'b0;
      tag2_v_q <= 1'b0;
      tag2_b_q <= 1'b0;
      waddr_q  <= 8'h00;
      raddr_q  <= 8'h00;
      wdata_q  <= 16'h0000;
      mask_q   <= 16'h0000;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      tag1_v_q <= 1'b0;
      tag1_b_q <= 1'b0;
      tag2_v_q <= tag1_v_q;
      tag2_b_q <= tag1_b_q;
      if (state_q == StClear) begin
        we_q    <= 1'b1;
        waddr_q <= cnt_q;
        wdata_q <= 16'h0000;
        mask_q  <= 16'h0000;
        cnt_q   <= cnt_q + 8'd1;  // wraps to 0 on the last sweep write
      end else if (accept) begin
        rr_q <= !sel_b;
        if (sel_we) begin
          we_q    <= 1'b1;
          waddr_q <= sel_addr;
          wdata_q <= sel_wdata;
          mask_q  <= sel_mask;
        end else begin
          re_q     <= 1'b1;
          raddr_q  <= sel_addr;
          tag1_v_q <= 1'b1;
          tag1_b_q <= sel_b;
        end
      end
    end
  end

  assign bram_waddr = waddr_q;
  assign bram_raddr = raddr_q;
  assign bram_wdata = wdata_q;
  assign bram_mask  = mask_q;
  assign bram_we    = we_q;
  assign bram_wclke = we_q;
  assign bram_re    = re_q;
  assign bram_rclke = re_q;

  assign a_rvalid = tag2_v_q && !tag2_b_q;
  assign b_rvalid = tag2_v_q && tag2_b_q;
  assign a_rdata  = bram_rdata;
  assign b_rdata  = bram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: one round-robin instance and one fixed-priority
// instance share the same stimulus.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we, clr_start;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, a_mask, b_wdata, b_mask, bram_rdata;

  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy;
  logic [15:0] a_rdata, b_rdata, bram_wdata, bram_mask;
  logic [7:0]  bram_waddr, bram_raddr;
  logic        bram_we, bram_wclke, bram_re, bram_rclke;

  logic        f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_clr_busy;
  logic [15:0] f_a_rdata, f_b_rdata, f_bram_wdata, f_bram_mask;
  logic [7:0]  f_bram_waddr, f_bram_raddr;
  logic        f_bram_we, f_bram_wclke, f_bram_re, f_bram_rclke;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.PRIO_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .bram_waddr(bram_waddr), .bram_raddr(bram_raddr), .bram_wdata(bram_wdata),
    .bram_mask(bram_mask), .bram_we(bram_we), .bram_wclke(bram_wclke),
    .bram_re(bram_re), .bram_rclke(bram_rclke), .bram_rdata(bram_rdata)
  );

  bram_arbiter #(.PRIO_MODE(0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
    .clr_start(clr_start), .clr_busy(f_clr_busy),
    .bram_waddr(f_bram_waddr), .bram_raddr(f_bram_raddr), .bram_wdata(f_bram_wdata),
    .bram_mask(f_bram_mask), .bram_we(f_bram_we), .bram_wclke(f_bram_wclke),
    .bram_re(f_bram_re), .bram_rclke(f_bram_rclke), .bram_rdata(bram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // {we, wclke, re, rclke}
  function automatic logic [3:0] ens();
    return {bram_we, bram_wclke, bram_re, bram_rclke};
  endfunction

  initial begin
    rst_n = 1'b0; clr_start = 1'b0; bram_rdata = 16'h0000;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000; a_mask = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000; b_mask = 16'h0000;

    // Reset state; a_req high but grant forced low during reset
    tick();
    tick();
    check("rst_a_gnt", a_gnt, 0);
    check("rst_fp_a_gnt", f_a_gnt, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_enables", ens(), 4'b0000);
    check("rst_addrs", {bram_waddr, bram_raddr}, 16'h0000);
    check("rst_data", {bram_wdata, bram_mask}, 32'h0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    a_req = 1'b0;
    rst_n = 1'b1;

    // A-only read
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #1;
    check("rd_a_gnt", {a_gnt, b_gnt}, 2'b10);
    tick();
    a_req = 1'b0;
    bram_rdata = 16'h1234;
    #1;
    check("rd_enables", ens(), 4'b0011);
    check("rd_raddr", bram_raddr, 8'h10);
    check("rd_early_rvalid", a_rvalid, 0);
    tick();
    check("rd_a_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    check("rd_a_rdata", a_rdata, 16'h1234);
    check("rd_idle_enables", ens(), 4'b0000);
    check("rd_raddr_hold", bram_raddr, 8'h10);
    tick();
    check("rd_rvalid_pulse", {a_rvalid, b_rvalid}, 2'b00);

    // Masked write from B
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 16'hBEEF; b_mask = 16'h00FF;
    #1;
    check("wr_b_gnt", {a_gnt, b_gnt}, 2'b01);
    tick();
    b_req = 1'b0;
    #1;
    check("wr_enables", ens(), 4'b1100);
    check("wr_fields", {bram_waddr, bram_wdata, bram_mask}, 40'hFF_BEEF_00FF);
    check("wr_raddr_hold", bram_raddr, 8'h10);
    tick();
    check("wr_no_rvalid1", {a_rvalid, b_rvalid}, 2'b00);
    check("wr_hold", {ens(), bram_waddr, bram_wdata}, {4'b0000, 24'hFF_BEEF});
    tick();
    check("wr_no_rvalid2", {a_rvalid, b_rvalid}, 2'b00);

    // Contention from reset: RR alternates A,B,A,B; fixed priority always A
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    #1;
    check("rr_c0", {a_gnt, b_gnt}, 2'b10);
    check("fp_c0", {f_a_gnt, f_b_gnt}, 2'b10);
    tick();
    check("rr_c1", {a_gnt, b_gnt}, 2'b01);
    check("fp_c1", {f_a_gnt, f_b_gnt}, 2'b10);
    check("rr_c1_raddr", bram_raddr, 8'h01);
    tick();
    check("rr_c2", {a_gnt, b_gnt}, 2'b10);
    check("fp_c2", {f_a_gnt, f_b_gnt}, 2'b10);
    check("rr_c2_raddr", bram_raddr, 8'h02);
    check("rr_c2_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    tick();
    check("rr_c3", {a_gnt, b_gnt}, 2'b01);
    check("fp_c3", {f_a_gnt, f_b_gnt}, 2'b10);
    check("rr_c3_rvalid", {a_rvalid, b_rvalid}, 2'b01);
    check("fp_c3_rvalid", {f_a_rvalid, f_b_rvalid}, 2'b10);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    tick();
    tick();

    // Read from B just before clear; its rvalid must land in the first CLEAR cycle
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h33;
    #1;
    check("pre_clr_b_gnt", b_gnt, 1);
    tick();
    b_req = 1'b0;
    clr_start = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h55; a_wdata = 16'hAAAA; a_mask = 16'h0F0F;
    #1;
    check("clr_start_gnt", a_gnt, 0);
    check("clr_start_busy", clr_busy, 0);
    tick();
    clr_start = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      check("clr_busy", clr_busy, 1);
      check("clr_gnt", {a_gnt, b_gnt}, 2'b00);
      if (i == 0) begin
        check("clr_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
        check("clr_first_en", ens(), 4'b0000);
      end else begin
        check("clr_sweep", {ens(), bram_waddr, bram_wdata, bram_mask},
              {4'b1100, 8'(i - 1), 32'h0});
      end
      if (i == 3) clr_start = 1'b1;  // ignored while clearing
      if (i == 4) clr_start = 1'b0;
      tick();
    end
    check("clr_done_busy", clr_busy, 0);
    check("clr_last_write", {ens(), bram_waddr, bram_wdata, bram_mask}, {4'b1100, 8'hFF, 32'h0});
    check("clr_done_gnt", a_gnt, 1);
    tick();
    a_req = 1'b0;
    #1;
    check("post_clr_write", {ens(), bram_waddr, bram_wdata, bram_mask},
          {4'b1100, 8'h55, 16'hAAAA, 16'h0F0F});
    tick();

    // Reset with a read in flight
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h44;
    #1;
    check("mid_gnt", a_gnt, 1);
    tick();
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_re", ens(), 4'b0011);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_no_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("mid_enables", ens(), 4'b0000);
    check("mid_raddr", bram_raddr, 8'h00);
    tick();
    check("mid_no_rvalid_late", {a_rvalid, b_rvalid}, 2'b00);

    // Reset during CLEAR aborts the sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    check("abort_busy_before", clr_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_busy_after", clr_busy, 0);
    check("abort_enables", ens(), 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
